// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the chunk-serial subtractor (sub_chunked32):
//   - DEF_WIDTH / DEF_CHUNK : default operand width and bits added per clock
//   - state_e               : controller state encoding (IDLE, CALC, DONE)
//   - nchunk()              : number of chunk cycles for a width/chunk pair
//   - idx_width()           : width of the chunk index register (at least 1)
// -----------------------------------------------------------------------------
package sub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_chunked32_if.sv
// -----------------------------------------------------------------------------
// sub_chunked32_if
// Handshake and data bundle of the chunk-serial subtractor.
//   Input side : in_valid, in_ready, a (minuend), b_inv (~subtrahend)
//   Output side: out_valid, out_ready, ans, cout, zf, sf, of
// Modports:
//   slave  - the subtractor itself
//   master - the surrounding producer/consumer (not32 stage, ALU result mux)
// -----------------------------------------------------------------------------
interface sub_chunked32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ans;
    logic             cout;
    logic             zf;
    logic             sf;
    logic             of;

    modport slave (
        input  in_valid, a, b_inv, out_ready,
        output in_ready, out_valid, ans, cout, zf, sf, of
    );

    modport master (
        output in_valid, a, b_inv, out_ready,
        input  in_ready, out_valid, ans, cout, zf, sf, of
    );
endinterface

// File: rtl/add_chunk.sv
// -----------------------------------------------------------------------------
// add_chunk
// Combinational W-bit adder with carry in and carry out; one slice of the
// chunk-serial ripple add.
//   a, b : addend slices
//   cin  : carry from the previous chunk
//   sum  : W-bit sum slice
//   cout : carry into the next chunk
// -----------------------------------------------------------------------------
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    // Widen by one bit so the carry falls out of the top of the sum
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/sub_chunked32.sv
// -----------------------------------------------------------------------------
// sub_chunked32
// Completes a - b for the ALU Sub path from the minuend a and the inverted
// subtrahend b_inv as a + b_inv + 1, CHUNK bits per clock (NCHUNK = WIDTH/CHUNK
// compute cycles). A one-deep transaction: accept in IDLE, ripple in CALC,
// present in DONE until the consumer takes it.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - sub_chunked32_if.slave: in_valid/in_ready/a/b_inv in,
//          out_valid/out_ready/ans/cout/zf/sf/of out
// Configuration macro: SUB_CC_FLAGS_EN
//   defined   - zf/sf/of registered when the last chunk completes
//   undefined - zf/sf/of tied to 0, flag logic not built
// -----------------------------------------------------------------------------
module sub_chunked32
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    sub_chunked32_if.slave   bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    if ((CHUNK <= 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("sub_chunked32: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_e             state_r;
    state_e             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_inv_r;
    logic [WIDTH-1:0]   ans_r;
    logic [WIDTH-1:0]   ans_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic               cout_r;
    logic [CHUNK-1:0]   chunk_a_s;
    logic [CHUNK-1:0]   chunk_b_s;
    logic [CHUNK-1:0]   chunk_sum_s;
    logic               chunk_cout_s;
    logic               last_s;
    logic               in_ready_s;
    logic               out_valid_s;

    assign last_s = (idx_r == IDX_LAST);

    // Select the current operand chunk and merge the new sum slice into ans
    always_comb begin
        chunk_a_s  = a_r[int'(idx_r) * CHUNK +: CHUNK];
        chunk_b_s  = b_inv_r[int'(idx_r) * CHUNK +: CHUNK];
        ans_next_s = ans_r;
        ans_next_s[int'(idx_r) * CHUNK +: CHUNK] = chunk_sum_s;
    end

    add_chunk #(.W(CHUNK)) u_add_chunk (
        .a    (chunk_a_s),
        .b    (chunk_b_s),
        .cin  (carry_r),
        .sum  (chunk_sum_s),
        .cout (chunk_cout_s)
    );

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Controller next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Controller outputs, decoded from the state register only
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Operand latch, chunk ripple and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_inv_r <= {WIDTH{1'b0}};
            ans_r   <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b1;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_inv_r <= bus.b_inv;
                        idx_r   <= {IDX_W{1'b0}};
                        // The +1 of two's complement enters as the first carry
                        carry_r <= 1'b1;
                    end
                end
                CALC: begin
                    ans_r   <= ans_next_s;
                    carry_r <= chunk_cout_s;
                    if (last_s) begin
                        cout_r <= chunk_cout_s;
                        idx_r  <= {IDX_W{1'b0}};
                    end else begin
                        idx_r  <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    ans_r <= ans_r;
                end
            endcase
        end
    end

`ifdef SUB_CC_FLAGS_EN
    logic zf_r;
    logic sf_r;
    logic of_r;

    // Condition codes captured together with the final chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_r <= 1'b0;
            sf_r <= 1'b0;
            of_r <= 1'b0;
        end else if ((state_r == CALC) && last_s) begin
            zf_r <= (ans_next_s == {WIDTH{1'b0}});
            sf_r <= ans_next_s[WIDTH-1];
            // Overflow: both addends share a sign that the sum does not
            of_r <= (a_r[WIDTH-1] == b_inv_r[WIDTH-1]) &&
                    (ans_next_s[WIDTH-1] != a_r[WIDTH-1]);
        end
    end

    assign bus.zf = zf_r;
    assign bus.sf = sf_r;
    assign bus.of = of_r;
`else
    assign bus.zf = 1'b0;
    assign bus.sf = 1'b0;
    assign bus.of = 1'b0;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.ans       = ans_r;
    assign bus.cout      = cout_r;

endmodule

// File: tb/tb_sub_chunked32.sv
// -----------------------------------------------------------------------------
// tb_sub_chunked32
// Self-checking bench for sub_chunked32 (WIDTH=32, CHUNK=8). Honours
// SUB_CC_FLAGS_EN: with the macro undefined, zf/sf/of are expected to be 0.
// -----------------------------------------------------------------------------
module tb_sub_chunked32;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

`ifdef SUB_CC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk;
    logic rst;

    sub_chunked32_if #(.WIDTH(WIDTH)) bus ();

    sub_chunked32 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b_inv;
        logic [31:0] ans;
        logic        cout;
        logic        zf;
        logic        sf;
        logic        of;
        int          hold;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain a - b with b = ~b_inv, using wide signed arithmetic
    task automatic model(input logic [31:0] a, input logic [31:0] bi,
                         output logic [31:0] ans, output logic c,
                         output logic z, output logic s, output logic o);
        logic [31:0] b;
        longint      sa;
        longint      sb;
        longint      diff;
        b    = ~bi;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        diff = sa - sb;
        ans  = a - b;
        c    = (a >= b);
        z    = FLAGS && (ans == 32'd0);
        s    = FLAGS && ans[31];
        o    = FLAGS && ((diff > 64'sd2147483647) || (diff < -64'sd2147483648));
    endtask

    // Present an operand pair until it is accepted, then scramble the inputs
    task automatic send(input logic [31:0] a, input logic [31:0] bi);
        bus.a        = a;
        bus.b_inv    = bi;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b_inv    = $urandom;
    endtask

    // Wait for the result (bounded), check it, stall `hold` cycles, retire it
    task automatic collect(input string nm, input logic [31:0] e_ans, input logic e_c,
                           input logic e_z, input logic e_s, input logic e_o, input int hold);
        int lat;
        lat = 0;
        while (!bus.out_valid && (lat < 40)) begin
            if (lat == 1) chk({nm, " in_ready_busy"}, 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        // Counting the accept edge itself, out_valid is up on edge NCHUNK+1
        chk({nm, " latency"}, 64'(lat + 1), 64'(NCHUNK + 1));
        chk({nm, " ans"},  64'(bus.ans),  64'(e_ans));
        chk({nm, " cout"}, 64'(bus.cout), 64'(e_c));
        chk({nm, " zf"},   64'(bus.zf),   64'(e_z));
        chk({nm, " sf"},   64'(bus.sf),   64'(e_s));
        chk({nm, " of"},   64'(bus.of),   64'(e_o));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({nm, " hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({nm, " hold_ans"},   64'(bus.ans),       64'(e_ans));
        end
        chk({nm, " in_ready_done"}, 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({nm, " retired"},  64'(bus.out_valid), 64'd0);
        chk({nm, " idle_rdy"}, 64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] e_ans;
        logic        e_c;
        logic        e_z;
        logic        e_s;
        logic        e_o;

        tbl[0] = '{32'd11,         ~32'd11,      32'd0,          1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{-32'sd11,       ~32'd11,      32'hFFFFFFEA,   1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{32'h7FFFFFFF,   32'h00000000, 32'h80000000,   1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[3] = '{32'd9,          32'h00000001, 32'd11,         1'b0, 1'b0, 1'b0, 1'b0, 6};
        tbl[4] = '{32'h80000000,   32'hFFFFFFFE, 32'h7FFFFFFF,   1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[5] = '{32'h00000000,   32'hFFFFFFFF, 32'h00000000,   1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[6] = '{32'h00000000,   32'hFFFFFFFE, 32'hFFFFFFFF,   1'b0, 1'b0, 1'b1, 1'b0, 2};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 32'd0;
        bus.b_inv     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst ans",       64'(bus.ans),       64'd0);
        chk("rst cout",      64'(bus.cout),      64'd0);
        chk("rst flags",     64'({bus.zf, bus.sf, bus.of}), 64'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].a, tbl[i].b_inv);
            collect($sformatf("tbl%0d", i), tbl[i].ans, tbl[i].cout,
                    FLAGS && tbl[i].zf, FLAGS && tbl[i].sf, FLAGS && tbl[i].of, tbl[i].hold);
        end

        // Reset in the second CALC cycle drops the partial result
        send(32'h12345678, 32'h00000000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst ans",       64'(bus.ans),       64'd0);
        chk("midrst cout",      64'(bus.cout),      64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst quiet", 64'(bus.out_valid), 64'd0);
        send(32'd11, ~32'd11);
        collect("post_rst", 32'd0, 1'b1, FLAGS, 1'b0, 1'b0, 0);

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = ~ra;
                1:       ra = 32'h80000000;
                2:       rb = 32'hFFFFFFFF;
                3:       rb = 32'h7FFFFFFF;
                default: ra = ra;
            endcase
            model(ra, rb, e_ans, e_c, e_z, e_s, e_o);
            send(ra, rb);
            collect($sformatf("rnd%0d", n), e_ans, e_c, e_z, e_s, e_o,
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
